// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-path controller.
package uart_pkg;

  localparam int         DIV_RST_DEFAULT = 53;
  localparam logic [7:0] ERR_CNT_MAX     = 8'd255;

  typedef struct packed {
    logic framing;
    logic parity;
  } rx_status_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO: head entry is visible combinationally on rdata.
module uart_rx_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 10,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive-path controller: baud tick, parity config, event FIFO and
// sticky overrun / saturating error-count status.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter  int DBITS   = 8,
  parameter  int DEPTH   = 8,
  parameter  int DIV_W   = 16,
  parameter  int DIV_RST = DIV_RST_DEFAULT,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_parity_en,
  input  logic             cfg_odd_even,
  input  logic             flush,
  input  logic             clr_status,
  output logic             baudx16_ena,
  output logic             parity_en,
  output logic             odd_even,
  input  logic [DBITS-1:0] rx_data,
  input  logic             rx_valid,
  input  logic             framing_err,
  input  logic             parity_err,
  output logic [DBITS-1:0] m_data,
  output logic [1:0]       m_err,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CW-1:0]    fifo_count,
  output logic             overrun,
  output logic [7:0]       err_cnt
);

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [DIV_W-1:0] cnt_nxt;

  // The tick is registered from the next counter value so it is high in
  // exactly the cycle where the counter sits at div_r.
  always_comb begin
    div_nxt = div_r;
    cnt_nxt = div_cnt + DIV_W'(1);
    if (cfg_wr) begin
      div_nxt = cfg_div;
      cnt_nxt = '0;
    end else if (div_cnt == div_r) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      div_r       <= DIV_W'(DIV_RST);
      div_cnt     <= '0;
      baudx16_ena <= 1'b0;
      parity_en   <= 1'b0;
      odd_even    <= 1'b0;
    end else begin
      div_r       <= div_nxt;
      div_cnt     <= cnt_nxt;
      baudx16_ena <= (cnt_nxt == div_nxt);
      if (cfg_wr) begin
        parity_en <= cfg_parity_en;
        odd_even  <= cfg_odd_even;
      end
    end
  end

  logic [2:0]           flags;
  logic [2:0]           evt_q;
  logic                 evt;
  logic                 err_evt;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 drop;
  rx_status_t           wstat;
  rx_status_t           rstat;
  logic [DBITS+1:0]     wdata;
  logic [DBITS+1:0]     rdata;

  assign flags   = {framing_err, parity_err, rx_valid};
  assign evt     = |(flags & ~evt_q);
  assign err_evt = evt && (framing_err || parity_err);
  assign pop     = m_valid && m_ready;
  // Events lost to flush are intentional and never count as overrun.
  assign drop    = evt && !flush && full && !pop;

  assign wstat   = '{framing: framing_err, parity: parity_err};
  assign wdata   = {rx_data, wstat};
  assign m_data  = rdata[DBITS+1:2];
  assign rstat   = rdata[1:0];
  assign m_err   = rstat;
  assign m_valid = !empty;

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DBITS + 2)
  ) u_fifo (
    .clk   (sysclk),
    .rst   (rst),
    .push  (evt),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .rdata (rdata),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      evt_q   <= 3'b000;
      overrun <= 1'b0;
      err_cnt <= '0;
    end else begin
      evt_q <= flags;
      if (drop)            overrun <= 1'b1;
      else if (clr_status) overrun <= 1'b0;
      if (clr_status)
        err_cnt <= err_evt ? 8'd1 : 8'd0;
      else if (err_evt && (err_cnt != ERR_CNT_MAX))
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int DBITS = 8;
  localparam int DEPTH = 8;
  localparam int DIV_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             sysclk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_wr = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_parity_en = 1'b0;
  logic             cfg_odd_even = 1'b0;
  logic             flush = 1'b0;
  logic             clr_status = 1'b0;
  logic             baudx16_ena;
  logic             parity_en;
  logic             odd_even;
  logic [DBITS-1:0] rx_data = '0;
  logic             rx_valid = 1'b0;
  logic             framing_err = 1'b0;
  logic             parity_err = 1'b0;
  logic [DBITS-1:0] m_data;
  logic [1:0]       m_err;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [CW-1:0]    fifo_count;
  logic             overrun;
  logic [7:0]       err_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [9:0] q[$];
  logic [2:0] prev_flags = 3'b000;
  logic       ov_m = 1'b0;
  int         errc_m = 0;

  always #5 sysclk = ~sysclk;

  uart_rx_ctrl #(.DBITS(DBITS), .DEPTH(DEPTH), .DIV_W(DIV_W), .DIV_RST(53)) dut (
    .sysclk(sysclk), .rst(rst), .cfg_wr(cfg_wr), .cfg_div(cfg_div),
    .cfg_parity_en(cfg_parity_en), .cfg_odd_even(cfg_odd_even),
    .flush(flush), .clr_status(clr_status), .baudx16_ena(baudx16_ena),
    .parity_en(parity_en), .odd_even(odd_even), .rx_data(rx_data),
    .rx_valid(rx_valid), .framing_err(framing_err), .parity_err(parity_err),
    .m_data(m_data), .m_err(m_err), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_count(fifo_count), .overrun(overrun), .err_cnt(err_cnt)
  );

  // Advance the model with the inputs currently applied, then clock once.
  task automatic step();
    logic [2:0] cur;
    logic ev, errev, popping, drop;
    int sz;
    cur = {framing_err, parity_err, rx_valid};
    ev = |(cur & ~prev_flags);
    prev_flags = cur;
    errev = ev && (framing_err || parity_err);
    sz = q.size();
    popping = (sz > 0) && m_ready && !flush;
    drop = 1'b0;
    if (flush) q.delete();
    else begin
      if (popping) void'(q.pop_front());
      if (ev) begin
        if (sz < DEPTH || popping) q.push_back({rx_data, framing_err, parity_err});
        else drop = 1'b1;
      end
    end
    if (drop) ov_m = 1'b1;
    else if (clr_status) ov_m = 1'b0;
    if (clr_status) errc_m = errev ? 1 : 0;
    else if (errev && errc_m < 255) errc_m++;
    @(posedge sysclk);
    #1;
    cfg_wr = 1'b0;
    flush = 1'b0;
    clr_status = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] d, input logic fe, input logic pe, input logic rv);
    rx_data = d;
    framing_err = fe;
    parity_err = pe;
    rx_valid = rv;
    step();
    framing_err = 1'b0;
    parity_err = 1'b0;
    rx_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    int first;
    rst = 1'b1;
    repeat (2) @(posedge sysclk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || fifo_count !== '0 || overrun !== 1'b0 || err_cnt !== 8'd0)
      begin errors++; $display("FAIL reset_status valid=%b count=%0d ov=%b err=%0d exp 0/0/0/0", m_valid, fifo_count, overrun, err_cnt); end
    checks++;
    if (baudx16_ena !== 1'b0 || parity_en !== 1'b0 || odd_even !== 1'b0)
      begin errors++; $display("FAIL reset_cfg ena=%b par=%b odd=%b exp 0", baudx16_ena, parity_en, odd_even); end
    rst = 1'b0;
    first = -1;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (baudx16_ena === 1'b1 && first < 0) first = k;
    end
    checks++;
    if (first != 53) begin errors++; $display("FAIL first_tick got edge %0d exp 53", first); end
  endtask

  task automatic test_tick();
    cfg_div = 16'd3; cfg_parity_en = 1'b1; cfg_odd_even = 1'b0; cfg_wr = 1'b1;
    step();
    checks++;
    if (parity_en !== 1'b1 || odd_even !== 1'b0)
      begin errors++; $display("FAIL cfg_parity1 par=%b odd=%b exp 1/0", parity_en, odd_even); end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (baudx16_ena !== ((k % 4) == 3))
        begin errors++; $display("FAIL tick_div3 k=%0d got %b exp %b", k, baudx16_ena, (k % 4) == 3); end
      step();
    end
    cfg_div = 16'd0; cfg_parity_en = 1'b0; cfg_odd_even = 1'b1; cfg_wr = 1'b1;
    step();
    checks++;
    if (parity_en !== 1'b0 || odd_even !== 1'b1)
      begin errors++; $display("FAIL cfg_parity2 par=%b odd=%b exp 0/1", parity_en, odd_even); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (baudx16_ena !== 1'b1) begin errors++; $display("FAIL tick_div0 k=%0d got %b exp 1", k, baudx16_ena); end
      step();
    end
    cfg_div = 16'd53; cfg_wr = 1'b1;
    step();
  endtask

  task automatic test_single();
    rx_data = 8'hA5; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || m_err !== 2'b00 || fifo_count !== CW'(1))
      begin errors++; $display("FAIL single_byte valid=%b data=%h err=%b count=%0d exp 1/a5/00/1", m_valid, m_data, m_err, fifo_count); end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || fifo_count !== '0)
      begin errors++; $display("FAIL single_pop valid=%b count=%0d exp 0/0", m_valid, fifo_count); end
  endtask

  task automatic test_held();
    rx_data = 8'h5A; rx_valid = 1'b1;
    repeat (5) step();
    rx_valid = 1'b0;
    step();
    checks++;
    if (fifo_count !== CW'(1) || m_data !== 8'h5A)
      begin errors++; $display("FAIL held_level count=%0d data=%h exp 1/5a", fifo_count, m_data); end
    m_ready = 1'b1; step(); m_ready = 1'b0;
  endtask

  task automatic test_errors();
    pulse(8'h3C, 1'b1, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_err !== 2'b10 || m_data !== 8'h3C || err_cnt !== 8'd1)
      begin errors++; $display("FAIL framing_entry valid=%b err=%b data=%h cnt=%0d exp 1/10/3c/1", m_valid, m_err, m_data, err_cnt); end
    m_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      pulse(8'(i), 1'b0, 1'b1, 1'b0);
      if (i == 252) begin
        checks++;
        if (err_cnt !== 8'd254) begin errors++; $display("FAIL err_cnt_254 got %0d exp 254", err_cnt); end
      end
    end
    m_ready = 1'b0;
    checks++;
    if (err_cnt !== 8'd255 || overrun !== 1'b0)
      begin errors++; $display("FAIL err_cnt_sat got %0d ov=%b exp 255/0", err_cnt, overrun); end
    clr_status = 1'b1;
    step();
    checks++;
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL err_clr got %0d exp 0", err_cnt); end
  endtask

  task automatic test_full();
    flush = 1'b1; clr_status = 1'b1; m_ready = 1'b0;
    step();
    for (int i = 0; i < 8; i++) pulse(8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
    checks++;
    if (fifo_count !== CW'(8) || overrun !== 1'b0)
      begin errors++; $display("FAIL full_count count=%0d ov=%b exp 8/0", fifo_count, overrun); end
    pulse(8'h99, 1'b0, 1'b0, 1'b1);
    checks++;
    if (fifo_count !== CW'(8) || overrun !== 1'b1 || m_data !== 8'h10)
      begin errors++; $display("FAIL full_drop count=%0d ov=%b head=%h exp 8/1/10", fifo_count, overrun, m_data); end
    clr_status = 1'b1;
    step();
    rx_data = 8'h77; rx_valid = 1'b1; m_ready = 1'b1;
    step();
    rx_valid = 1'b0; m_ready = 1'b0;
    step();
    checks++;
    if (fifo_count !== CW'(8) || overrun !== 1'b0 || m_data !== 8'h11)
      begin errors++; $display("FAIL full_push_pop count=%0d ov=%b head=%h exp 8/0/11", fifo_count, overrun, m_data); end
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({m_data, m_err} !== q[0]) begin errors++; $display("FAIL drain_order i=%0d got %h exp %h", i, {m_data, m_err}, q[0]); end
      step();
    end
    m_ready = 1'b0;
  endtask

  task automatic test_flush();
    int err_before;
    for (int i = 0; i < 5; i++) pulse(8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
    err_before = int'(err_cnt);
    flush = 1'b1; framing_err = 1'b1; m_ready = 1'b1;
    step();
    framing_err = 1'b0; m_ready = 1'b0;
    step();
    checks++;
    if (fifo_count !== '0 || m_valid !== 1'b0 || overrun !== 1'b0)
      begin errors++; $display("FAIL flush count=%0d valid=%b ov=%b exp 0/0/0", fifo_count, m_valid, overrun); end
    checks++;
    if (int'(err_cnt) != err_before + 1)
      begin errors++; $display("FAIL flush_err_cnt got %0d exp %0d", err_cnt, err_before + 1); end
  endtask

  task automatic test_clr();
    m_ready = 1'b1;
    repeat (3) pulse(8'h01, 1'b0, 1'b1, 1'b0);
    clr_status = 1'b1; parity_err = 1'b1;
    step();
    parity_err = 1'b0;
    checks++;
    if (err_cnt !== 8'd1) begin errors++; $display("FAIL clr_with_error got %0d exp 1", err_cnt); end
    step();
    m_ready = 1'b0;
  endtask

  task automatic test_random();
    cfg_div = 16'd2; cfg_wr = 1'b1;
    step();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) {framing_err, parity_err, rx_valid} = 3'($urandom_range(0, 7));
      rx_data = 8'($urandom);
      m_ready = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 49) == 0);
      clr_status = ($urandom_range(0, 39) == 0);
      step();
      checks++;
      if (int'(fifo_count) != q.size() || m_valid !== (q.size() > 0))
        begin errors++; $display("FAIL rand_count c=%0d count=%0d valid=%b exp %0d", c, fifo_count, m_valid, q.size()); end
      checks++;
      if (overrun !== ov_m || int'(err_cnt) != errc_m)
        begin errors++; $display("FAIL rand_status c=%0d ov=%b err=%0d exp %b/%0d", c, overrun, err_cnt, ov_m, errc_m); end
      if (q.size() > 0) begin
        checks++;
        if ({m_data, m_err} !== q[0])
          begin errors++; $display("FAIL rand_head c=%0d got %h exp %h", c, {m_data, m_err}, q[0]); end
      end
    end
    {framing_err, parity_err, rx_valid} = 3'b000;
    m_ready = 1'b0;
    step();
  endtask

  task automatic test_midreset();
    cfg_div = 16'd0; cfg_parity_en = 1'b1; cfg_odd_even = 1'b1; cfg_wr = 1'b1;
    step();
    for (int i = 0; i < 3; i++) pulse(8'(i), 1'b1, 1'b0, 1'b0);
    @(negedge sysclk);
    rst = 1'b1;
    #1;
    checks++;
    if (fifo_count !== '0 || m_valid !== 1'b0 || err_cnt !== 8'd0 || overrun !== 1'b0)
      begin errors++; $display("FAIL midreset_fifo count=%0d valid=%b err=%0d ov=%b exp 0", fifo_count, m_valid, err_cnt, overrun); end
    checks++;
    if (baudx16_ena !== 1'b0 || parity_en !== 1'b0 || odd_even !== 1'b0)
      begin errors++; $display("FAIL midreset_cfg ena=%b par=%b odd=%b exp 0", baudx16_ena, parity_en, odd_even); end
    q.delete(); prev_flags = 3'b000; ov_m = 1'b0; errc_m = 0;
    @(posedge sysclk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tick();
    test_single();
    test_held();
    test_errors();
    test_full();
    test_flush();
    test_clr();
    test_random();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
